rv32i_inst_encode: RTL and testbench

Converts a field-level RV32I instruction description (format, opcode, registers, functs, 32-bit immediate) into a 32-bit instruction word. It is the inverse of the core's immediate decoders. It feeds the debug program buffer and the self-test instruction injector ahead of IFU/EXU. Each accepted request is range-checked and encoded. Results queue in a 2-entry output buffer with valid/ready handshakes on both sides, and saturating counters track accepted and rejected encodings.

---
 rtl/rv32i_inst_encode.sv | 151 +++++++++++++++
 tb/tb_rv32i_inst_encode.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_inst_encode.sv
// rv32i_inst_encode
//   Builds a 32-bit RV32I instruction word from a field-level description
//   (format, opcode, rd/rs1/rs2, funct3/funct7, architectural immediate).
//   This is the inverse of the core's immediate decoders. Each accepted
//   request is range-checked, encoded and queued in a 2-entry output buffer.
//   Saturating counters track popped good and error results.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_vld/in_rdy   request handshake (accept when both high)
//   in_fmt          0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                   instruction fields; in_imm is already sign-extended
//   out_vld/out_rdy result handshake (pop when both high)
//   out_inst        encoded word (0 when out_err)
//   out_err         immediate not representable or illegal format
//   good_cnt        popped results with out_err=0, saturating
//   err_cnt         popped results with out_err=1, saturating
module rv32i_inst_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // An immediate fits in N signed bits when everything from the sign bit
    // upward is a copy of that sign bit.
    logic s12_ok;   // fits 12-bit signed (I/S)
    logic s13_ok;   // fits 13-bit signed (B)
    logic s21_ok;   // fits 21-bit signed (J)

    assign s12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign s13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign s21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    logic [31:0] enc_inst;
    logic        enc_err;

    always_comb begin
        enc_inst = '0;
        enc_err  = 1'b0;
        case (in_fmt)
            FMT_R: begin
                enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_I: begin
                enc_err  = ~s12_ok;
                enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_S: begin
                enc_err  = ~s12_ok;
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], in_opcode};
            end
            FMT_B: begin
                enc_err  = ~s13_ok | in_imm[0];
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            end
            FMT_U: begin
                enc_err  = |in_imm[11:0];
                enc_inst = {in_imm[31:12], in_rd, in_opcode};
            end
            FMT_J: begin
                enc_err  = ~s21_ok | in_imm[0];
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
        // Rejected requests carry a zero word so nothing half-encoded leaks out.
        if (enc_err)
            enc_inst = '0;
    end

    // 2-entry output buffer
    logic [1:0][31:0] buf_inst;
    logic [1:0]       buf_err;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // in_rdy comes only from registered count, so there is no path from out_rdy.
    assign in_rdy   = (count != 2'd2);
    assign out_vld  = (count != 2'd0);
    assign out_inst = buf_inst[rd_ptr];
    assign out_err  = buf_err[rd_ptr];
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_inst <= '0;
            buf_err  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                buf_inst[wr_ptr] <= enc_inst;
                buf_err[wr_ptr]  <= enc_err;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                if (buf_err[rd_ptr]) begin
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + CNT_W'(1);
                end else begin
                    if (good_cnt != '1)
                        good_cnt <= good_cnt + CNT_W'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_inst_encode.sv
// Self-checking bench for rv32i_inst_encode. Expected results are pushed to a
// scoreboard when a request is accepted and compared when the DUT pops them.
module tb_rv32i_inst_encode;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [32:0] sb_q[$];
    logic [32:0] mon_exp;

    rv32i_inst_encode #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .good_cnt  (good_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a pop happens at the next rising edge when out_vld && out_rdy
    // are high at the falling edge (inputs only change just after rising edges).
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow got inst=%h err=%b with nothing expected", out_inst, out_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({out_err, out_inst} !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_pop got inst=%h err=%b expected inst=%h err=%b",
                             out_inst, out_err, mon_exp[31:0], mon_exp[32]);
                end
            end
        end
    end

    // Drive one request and hold it until accepted; returns 1ns after the
    // accepting edge with in_vld low.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] e_inst, input logic e_err);
        int n = 0;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_vld = 1'b1;
        while (!in_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_rdy stayed 0 for %0d cycles", n);
            in_vld = 1'b0;
        end else begin
            sb_q.push_back({e_err, e_inst});
            @(posedge clk); #1;
            in_vld = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((out_vld || sb_q.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL drain_timeout out_vld=%b pending=%0d required 0/0", out_vld, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks += 4;
        if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got %b expected 0", out_vld); end
        if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got %b expected 1", in_rdy); end
        if (good_cnt !== 16'd0) begin failures++; $display("FAIL reset_good_cnt got %h expected 0", good_cnt); end
        if ({out_err, out_inst} !== 33'd0) begin failures++; $display("FAIL reset_out got %b/%h expected 0/0", out_err, out_inst); end
    endtask

    task automatic test_i_latency();
        out_rdy = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        checks++;
        if (out_vld !== 1'b1) begin failures++; $display("FAIL i_latency out_vld got %b expected 1", out_vld); end
        @(posedge clk); #1;
        checks++;
        if (good_cnt !== 16'd1) begin failures++; $display("FAIL i_good_cnt got %0d expected 1", good_cnt); end
    endtask

    task automatic test_formats();
        out_rdy = 1'b1;
        send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd4,         32'h0021_A223, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,         32'h0080_00EF, 1'b0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
        drain();
        checks++;
        if (good_cnt !== 16'd6) begin failures++; $display("FAIL fmt_good_cnt got %0d expected 6", good_cnt); end
    endtask

    task automatic test_errors();
        logic [15:0] g0;
        logic [15:0] e0;
        g0 = good_cnt; e0 = err_cnt;
        out_rdy = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'd0, 1'b1);
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,         32'd0, 1'b1);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'd0, 1'b1);
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'd0, 1'b1);
        drain();
        checks += 2;
        if (err_cnt !== e0 + 16'd4) begin failures++; $display("FAIL err_cnt got %0d expected %0d", err_cnt, e0 + 16'd4); end
        if (good_cnt !== g0) begin failures++; $display("FAIL err_good_cnt got %0d expected %0d", good_cnt, g0); end
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b0;
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, 1'b0);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0193, 1'b0);
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL full_in_rdy got %b expected 0", in_rdy); end
        // third request held while the buffer is full; head must not move
        in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd4; in_rs1 = 5'd0; in_imm = 32'd3;
        in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_rdy !== 1'b0 || out_inst !== 32'h0010_0113 || out_vld !== 1'b1) begin
                failures++;
                $display("FAIL hold_head in_rdy=%b out_vld=%b inst=%h expected 0/1/00100113", in_rdy, out_vld, out_inst);
            end
        end
        out_rdy = 1'b1;
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0213, 1'b0);
        drain();
        // push and pop in the same cycle with one entry buffered
        out_rdy = 1'b0;
        send(3'd4, 7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E337, 1'b0);
        out_rdy = 1'b1;
        send(3'd4, 7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1397, 1'b0);
        checks++;
        if (out_vld !== 1'b1 || in_rdy !== 1'b1 || out_inst !== 32'h0000_1397) begin
            failures++;
            $display("FAIL push_pop out_vld=%b in_rdy=%b inst=%h expected 1/1/00001397", out_vld, in_rdy, out_inst);
        end
        drain();
    endtask

    task automatic test_mid_reset();
        out_rdy = 1'b0;
        send(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0010_80B3, 1'b0);
        send(3'd0, 7'h33, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0021_0133, 1'b0);
        checks++;
        if (in_rdy !== 1'b0) begin failures++; $display("FAIL mid_full got in_rdy=%b expected 0", in_rdy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        checks += 3;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin failures++; $display("FAIL mid_reset_hs out_vld=%b in_rdy=%b expected 0/1", out_vld, in_rdy); end
        if (good_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_cnt good=%0d err=%0d expected 0/0", good_cnt, err_cnt); end
        if ({out_err, out_inst} !== 33'd0) begin failures++; $display("FAIL mid_reset_out got %b/%h expected 0/0", out_err, out_inst); end
    endtask

    task automatic test_saturation();
        logic [4:0] r1, r2, rd;
        logic [2:0] f3;
        out_rdy = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom); f3 = 3'($urandom);
            send(3'd0, 7'h33, rd, r1, r2, f3, 7'd0, $urandom, {7'd0, r2, r1, f3, rd, 7'h33}, 1'b0);
        end
        drain();
        checks++;
        if (good_cnt !== 16'hFFFF) begin failures++; $display("FAIL good_sat got %h expected ffff", good_cnt); end
        send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
        drain();
        checks++;
        if (err_cnt !== 16'd1 || good_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_after_err good=%h err=%0d expected ffff/1", good_cnt, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        test_reset();
        test_i_latency();
        test_formats();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
